// File: rtl/dmem_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stack_if
//  Description : Request/response bundle between the MEM stage and the
//                byte-lane data memory / hardware stack engine.
//                master : issues req_* and receives rsp_*
//                slave  : the engine; accepts req_* and returns rsp_*
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_stack_if #(
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [1:0]        rsp_err_code;

    modport master (
        output req_valid, req_op, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );

    modport slave (
        input  req_valid, req_op, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );
endinterface
`default_nettype wire

// File: rtl/dmem_stack_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_stack_engine
//  Description : Byte-addressable data memory with a built-in hardware stack.
//                Serves LOAD / STORE / PUSH / POP one byte per cycle through a
//                single byte lane, with bounds, alignment and stack checks.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - dmem_stack_if.slave request/response bundle
//                sp     - current stack pointer (ADDR_W+1 bits)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_stack_engine #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int STACK_BASE  = 2**ADDR_W,
    parameter int STACK_LIMIT = 2**ADDR_W - 1024
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    dmem_stack_if.slave      bus,
    output logic [ADDR_W:0]  sp
);
    localparam int c_NB    = DATA_W / 8;
    localparam int c_CW    = $clog2(c_NB);
    localparam int c_DEPTH = 2**ADDR_W;

    localparam logic [32:0]       c_SPAN33   = 33'(c_DEPTH);
    localparam logic [32:0]       c_BASE33   = 33'(STACK_BASE);
    localparam logic [32:0]       c_LIMNB33  = 33'(STACK_LIMIT + c_NB);
    localparam logic [32:0]       c_NB33     = 33'(c_NB);
    localparam logic [ADDR_W:0]   c_BASE     = (ADDR_W+1)'(STACK_BASE);
    localparam logic [ADDR_W:0]   c_NB_SP    = (ADDR_W+1)'(c_NB);
    localparam logic [c_CW-1:0]   c_NB_M1    = c_CW'(c_NB - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    localparam logic [2:0] c_OP_LOAD  = 3'd1;
    localparam logic [2:0] c_OP_STORE = 3'd2;
    localparam logic [2:0] c_OP_PUSH  = 3'd3;
    localparam logic [2:0] c_OP_POP   = 3'd4;

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_ALIGN = 2'd1;
    localparam logic [1:0] c_ERR_RANGE = 2'd2;
    localparam logic [1:0] c_ERR_STACK = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [ADDR_W:0]    r_sp;
    logic               r_write;
    logic               r_pop;
    logic               r_signed;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    r_last;
    logic               r_err;
    logic [1:0]         r_code;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [1:0]         r_rsp_code;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic [7:0]         r_mem [c_DEPTH];

    // ------------------------------------------------------------------
    // Request decode and acceptance checks (priority encoded)
    // ------------------------------------------------------------------
    logic              w_is_ls;
    logic              w_is_push;
    logic              w_is_pop;
    logic              w_accept;
    logic [3:0]        w_ls_bytes;
    logic [3:0]        w_ls_m1;
    logic [32:0]       w_addr33;
    logic [32:0]       w_sp33;
    logic [ADDR_W:0]   w_sp_dec;
    logic              w_bad_size;
    logic              w_misalign;
    logic              w_oor;
    logic              w_ovf;
    logic              w_unf;
    logic              w_err;
    logic [1:0]        w_code;

    always_comb begin
        w_is_ls    = (bus.req_op == c_OP_LOAD) || (bus.req_op == c_OP_STORE);
        w_is_push  = (bus.req_op == c_OP_PUSH);
        w_is_pop   = (bus.req_op == c_OP_POP);
        w_accept   = (r_state == S_IDLE) && bus.req_valid && (w_is_ls || w_is_push || w_is_pop);
        w_ls_bytes = 4'd1 << bus.req_size;
        w_ls_m1    = w_ls_bytes - 4'd1;
        w_addr33   = {1'b0, bus.req_addr};
        w_sp33     = 33'(r_sp);
        w_sp_dec   = r_sp - c_NB_SP;

        w_bad_size = w_is_ls && ({28'd0, w_ls_bytes} > 32'(c_NB));
        w_misalign = w_is_ls && ((bus.req_addr[3:0] & w_ls_m1) != 4'd0);
        w_oor      = w_is_ls && ((w_addr33 + 33'(w_ls_bytes)) > c_SPAN33);
        // sp - NB < LIMIT rewritten as sp < LIMIT + NB to stay unsigned
        w_ovf      = w_is_push && (w_sp33 < c_LIMNB33);
        w_unf      = w_is_pop && ((w_sp33 + c_NB33) > c_BASE33);

        w_err  = 1'b1;
        w_code = c_ERR_NONE;
        if (w_bad_size || w_misalign) w_code = c_ERR_ALIGN;
        else if (w_oor)               w_code = c_ERR_RANGE;
        else if (w_ovf || w_unf)      w_code = c_ERR_STACK;
        else                          w_err  = 1'b0;
    end

    // ------------------------------------------------------------------
    // Narrow-load extension: bits above the last loaded byte are filled
    // with zero or with the top bit of that byte.
    // ------------------------------------------------------------------
    logic              w_msb;
    logic [DATA_W-1:0] w_ext;

    always_comb begin
        w_msb = r_acc[{r_last, 3'b111}];
        w_ext = r_acc;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= 8 * (int'(r_last) + 1)) w_ext[i] = r_signed & w_msb;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_sp        <= c_BASE;
            r_write     <= 1'b0;
            r_pop       <= 1'b0;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_err       <= 1'b0;
            r_code      <= c_ERR_NONE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= c_ERR_NONE;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= c_ERR_NONE;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_write  <= (bus.req_op == c_OP_STORE) || w_is_push;
                        r_pop    <= w_is_pop;
                        r_signed <= bus.req_signed;
                        r_wdata  <= bus.req_wdata;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_last   <= w_is_ls ? w_ls_m1[c_CW-1:0] : c_NB_M1;
                        r_err    <= w_err;
                        r_code   <= w_code;
                        if (w_is_push)     r_addr <= w_sp_dec[ADDR_W-1:0];
                        else if (w_is_pop) r_addr <= r_sp[ADDR_W-1:0];
                        else               r_addr <= bus.req_addr[ADDR_W-1:0];
                        if (w_err) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_XFER;
                            if (w_is_push) r_sp <= w_sp_dec;
                        end
                    end
                end
                S_XFER: begin
                    if (!r_write) r_acc[{r_cnt, 3'b000} +: 8] <= r_mem[r_addr];
                    r_wdata <= r_wdata >> 8;
                    r_addr  <= r_addr + c_ADDR_ONE;
                    if (r_cnt == r_last) begin
                        r_state <= S_RESP;
                        if (r_pop) r_sp <= r_sp + c_NB_SP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    r_rsp_code  <= r_code;
                    r_rsp_rdata <= (r_err || r_write) ? '0 : w_ext;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Byte-lane storage; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (r_state == S_XFER && r_write) r_mem[r_addr] <= r_wdata[7:0];
    end

    assign bus.req_ready    = r_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.rsp_err_code = r_rsp_code;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign sp               = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stack_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_stack_engine
//  Description : Scoreboard bench for dmem_stack_engine. A 32-bit and a 64-bit
//                instance share clock and reset; directed requests push their
//                expected responses into per-instance queues that independent
//                monitors pop on every rsp_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_stack_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_stack_if #(.DATA_W(32)) bus32 ();
    dmem_stack_if #(.DATA_W(64)) bus64 ();
    logic [12:0] sp32;
    logic [12:0] sp64;

    dmem_stack_engine #(.DATA_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32), .sp(sp32));
    dmem_stack_engine #(.DATA_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64), .sp(sp64));

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [2:0] NOP = 3'd0, LD = 3'd1, ST = 3'd2, PU = 3'd3, PO = 3'd4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [2:0] op, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [63:0] wd);
        if (d == 0) begin
            bus32.req_valid = v; bus32.req_op = op; bus32.req_size = size;
            bus32.req_signed = sgn; bus32.req_addr = addr; bus32.req_wdata = wd[31:0];
        end else begin
            bus64.req_valid = v; bus64.req_op = op; bus64.req_size = size;
            bus64.req_signed = sgn; bus64.req_addr = addr; bus64.req_wdata = wd;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus32.req_ready : bus64.req_ready;
    endfunction

    // Issue one request and queue its expected response.
    task automatic issue(input int d, input logic [2:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] erd,
                         input logic eerr, input logic [1:0] ecode, input int elat);
        exp_t e;
        int t;
        @(negedge clk);
        drive(d, 1'b1, op, size, sgn, addr, wd);
        t = 0;
        while (rdy(d) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (dut %0d)", d);
            drive(d, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
            return;
        end
        @(posedge clk);
        #1;
        e.rdata = erd; e.err = eerr; e.code = ecode; e.lat = elat; e.acc = cyc;
        if (d == 0) q32.push_back(e); else q64.push_back(e);
        drive(d, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q32.size() != 0 || q64.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: got %0d/%0d pending expected 0", q32.size(), q64.size());
            q32.delete(); q64.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus32.rsp_valid === 1'b1) begin
                if (q32.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp32_unexpected: got rsp_valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = q32.pop_front();
                    chk("rsp32_rdata", {32'd0, bus32.rsp_rdata}, e.rdata);
                    chk("rsp32_err", {63'd0, bus32.rsp_err}, {63'd0, e.err});
                    chk("rsp32_code", {62'd0, bus32.rsp_err_code}, {62'd0, e.code});
                    chk("rsp32_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end else begin
                chk("rsp32_idle_err", {61'd0, bus32.rsp_err, bus32.rsp_err_code}, 64'd0);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus64.rsp_valid === 1'b1) begin
                if (q64.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp64_unexpected: got rsp_valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = q64.pop_front();
                    chk("rsp64_rdata", bus64.rsp_rdata, e.rdata);
                    chk("rsp64_err", {63'd0, bus64.rsp_err}, {63'd0, e.err});
                    chk("rsp64_code", {62'd0, bus64.rsp_err_code}, {62'd0, e.code});
                    chk("rsp64_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(0, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
        drive(1, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, bus32.req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, bus32.rsp_valid}, 64'd0);
        chk("reset_rdata", {32'd0, bus32.rsp_rdata}, 64'd0);
        chk("reset_sp32", {51'd0, sp32}, 64'd4096);
        chk("reset_sp64", {51'd0, sp64}, 64'd4096);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store, narrow loads
        issue(0, ST, 2'd2, 1'b0, 32'h100, 64'hA1B2C3D4, 64'h0, 1'b0, 2'd0, 5);
        issue(0, LD, 2'd0, 1'b1, 32'h103, 64'h0, 64'hFFFFFFA1, 1'b0, 2'd0, 2);
        issue(0, LD, 2'd0, 1'b0, 32'h103, 64'h0, 64'h000000A1, 1'b0, 2'd0, 2);
        issue(0, LD, 2'd1, 1'b0, 32'h100, 64'h0, 64'h0000C3D4, 1'b0, 2'd0, 3);
        issue(0, LD, 2'd1, 1'b1, 32'h102, 64'h0, 64'hFFFFA1B2, 1'b0, 2'd0, 3);
        issue(0, LD, 2'd2, 1'b0, 32'h100, 64'h0, 64'hA1B2C3D4, 1'b0, 2'd0, 5);
        drain();

        // NOPs (op 0 and 7) produce no response
        @(negedge clk);
        drive(0, 1'b1, 3'd7, 2'd0, 1'b0, 32'h100, 64'd0);
        @(negedge clk);
        drive(0, 1'b1, NOP, 2'd0, 1'b0, 32'h100, 64'd0);
        @(negedge clk);
        drive(0, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
        repeat (4) @(negedge clk);
        chk("nop_ready", {63'd0, bus32.req_ready}, 64'd1);

        // Push / pop
        issue(0, PU, 2'd0, 1'b0, 32'h0, 64'h11111111, 64'h0, 1'b0, 2'd0, 5);
        drain();
        chk("sp_after_push1", {51'd0, sp32}, 64'd4092);
        issue(0, PU, 2'd0, 1'b0, 32'h0, 64'h22222222, 64'h0, 1'b0, 2'd0, 5);
        drain();
        chk("sp_after_push2", {51'd0, sp32}, 64'd4088);
        issue(0, PO, 2'd0, 1'b0, 32'h0, 64'h0, 64'h22222222, 1'b0, 2'd0, 5);
        issue(0, PO, 2'd0, 1'b0, 32'h0, 64'h0, 64'h11111111, 1'b0, 2'd0, 5);
        drain();
        chk("sp_after_pops", {51'd0, sp32}, 64'd4096);
        issue(0, PO, 2'd0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1, 2'd3, 1);
        drain();
        chk("sp_after_underflow", {51'd0, sp32}, 64'd4096);

        // Fill to the limit, then overflow
        issue(0, ST, 2'd2, 1'b0, 32'hBFC, 64'h5A5A5A5A, 64'h0, 1'b0, 2'd0, 5);
        for (int i = 0; i < 256; i++)
            issue(0, PU, 2'd0, 1'b0, 32'h0, 64'(i), 64'h0, 1'b0, 2'd0, 5);
        drain();
        chk("sp_at_limit", {51'd0, sp32}, 64'd3072);
        issue(0, PU, 2'd0, 1'b0, 32'h0, 64'hDEADDEAD, 64'h0, 1'b1, 2'd3, 1);
        drain();
        chk("sp_after_overflow", {51'd0, sp32}, 64'd3072);
        issue(0, LD, 2'd2, 1'b0, 32'hBFC, 64'h0, 64'h5A5A5A5A, 1'b0, 2'd0, 5);
        issue(0, PO, 2'd0, 1'b0, 32'h0, 64'h0, 64'h000000FF, 1'b0, 2'd0, 5);
        drain();
        chk("sp_after_limit_pop", {51'd0, sp32}, 64'd3076);

        // Alignment / range errors and the top-of-memory boundary
        issue(0, LD, 2'd2, 1'b0, 32'h102, 64'h0, 64'h0, 1'b1, 2'd1, 1);
        issue(0, LD, 2'd2, 1'b0, 32'hFFE, 64'h0, 64'h0, 1'b1, 2'd1, 1);
        issue(0, LD, 2'd0, 1'b0, 32'h1000, 64'h0, 64'h0, 1'b1, 2'd2, 1);
        issue(0, ST, 2'd2, 1'b0, 32'h102, 64'h99999999, 64'h0, 1'b1, 2'd1, 1);
        issue(0, ST, 2'd0, 1'b0, 32'h1000, 64'h77, 64'h0, 1'b1, 2'd2, 1);
        issue(0, LD, 2'd2, 1'b0, 32'h100, 64'h0, 64'hA1B2C3D4, 1'b0, 2'd0, 5);
        issue(0, ST, 2'd2, 1'b0, 32'hFFC, 64'hCAFEF00D, 64'h0, 1'b0, 2'd0, 5);
        issue(0, LD, 2'd2, 1'b0, 32'hFFC, 64'h0, 64'hCAFEF00D, 1'b0, 2'd0, 5);
        issue(0, LD, 2'd3, 1'b0, 32'h100, 64'h0, 64'h0, 1'b1, 2'd1, 1);
        drain();

        // 64-bit instance
        issue(1, ST, 2'd3, 1'b0, 32'h200, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2'd0, 9);
        issue(1, LD, 2'd3, 1'b0, 32'h200, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2'd0, 9);
        issue(1, LD, 2'd2, 1'b1, 32'h204, 64'h0, 64'h0000000001234567, 1'b0, 2'd0, 5);
        issue(1, LD, 2'd0, 1'b1, 32'h200, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, 2'd0, 2);
        issue(1, LD, 2'd1, 1'b1, 32'h202, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0, 2'd0, 3);
        issue(1, LD, 2'd3, 1'b0, 32'h204, 64'h0, 64'h0, 1'b1, 2'd1, 1);
        issue(1, PU, 2'd0, 1'b0, 32'h0, 64'hDEADBEEF00C0FFEE, 64'h0, 1'b0, 2'd0, 9);
        drain();
        chk("sp64_after_push", {51'd0, sp64}, 64'd4088);
        issue(1, PO, 2'd0, 1'b0, 32'h0, 64'h0, 64'hDEADBEEF00C0FFEE, 1'b0, 2'd0, 9);
        drain();
        chk("sp64_after_pop", {51'd0, sp64}, 64'd4096);

        // Reset in the middle of a word PUSH
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, ST, 2'd2, 1'b0, 32'hFFC, 64'h00000000, 64'h0, 1'b0, 2'd0, 5);
        drain();
        drive(0, 1'b1, PU, 2'd0, 1'b0, 32'h0, 64'hAABBCCDD);
        @(posedge clk);
        #1;
        drive(0, 1'b0, NOP, 2'd0, 1'b0, 32'd0, 64'd0);
        chk("mid_push_sp", {51'd0, sp32}, 64'd4092);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sp", {51'd0, sp32}, 64'd4096);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_ready", {63'd0, bus32.req_ready}, 64'd1);
        chk("abort_sp_after", {51'd0, sp32}, 64'd4096);
        issue(0, LD, 2'd2, 1'b0, 32'hFFC, 64'h0, 64'h0000CCDD, 1'b0, 2'd0, 5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
